// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel active-low push-button synchroniser/debouncer
// with per-channel stability counters and press/release pulses.
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   key_n       raw active-low buttons (asynchronous)
//   key_state   debounced level, 1 = pressed
//   key_press   one-cycle pulse per accepted press (and per auto-repeat)
//   key_release one-cycle pulse per accepted release
//   any_press   OR of key_press, registered alongside it
// Optional: define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses
// (REPEAT_DELAY after the press, then every REPEAT_PERIOD while held).
module debounce_multi #(
  parameter int N             = 4,
  parameter int DB_CYCLES     = 262144,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_n,
  output logic [N-1:0] key_state,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic         any_press
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [N-1:0] s1, s2, m, fire, press_nx, rel_nx;
  logic [CW-1:0] cnt [N];
`ifdef DEBOUNCE_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rcnt [N];
  logic [N-1:0] rfirst, rep;
`endif
  assign m = ~s2 ^ key_state;
  always_comb begin
    fire = '0;
    for (int i = 0; i < N; i++)
      fire[i] = m[i] && cnt[i] == CW'(DB_CYCLES - 1);
    press_nx = fire & ~key_state;
    rel_nx   = fire & key_state;
`ifdef DEBOUNCE_REPEAT_EN
    rep = '0;
    // a release accepted on the same edge suppresses the repeat pulse
    for (int i = 0; i < N; i++)
      rep[i] = key_state[i] && !fire[i] &&
               rcnt[i] == RW'((rfirst[i] ? REPEAT_DELAY : REPEAT_PERIOD) - 1);
    press_nx = press_nx | rep;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1          <= '1;
      s2          <= '1;
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_press   <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
      rfirst <= '1;
      for (int i = 0; i < N; i++) rcnt[i] <= '0;
`endif
    end else begin
      s1          <= key_n;
      s2          <= s1;
      key_state   <= key_state ^ fire;
      key_press   <= press_nx;
      key_release <= rel_nx;
      any_press   <= |press_nx;
      for (int i = 0; i < N; i++)
        cnt[i] <= (m[i] && !fire[i]) ? cnt[i] + CW'(1) : '0;
`ifdef DEBOUNCE_REPEAT_EN
      for (int i = 0; i < N; i++) begin
        if (fire[i] || !key_state[i]) begin
          rcnt[i]   <= '0;
          rfirst[i] <= 1'b1;
        end else if (rep[i]) begin
          rcnt[i]   <= '0;
          rfirst[i] <= 1'b0;
        end else begin
          rcnt[i]   <= rcnt[i] + RW'(1);
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: randomized and directed checks of debounce_multi against a window-based reference model
module tb_debounce_multi;
  localparam int N = 2, DB = 4, RD = 10, RP = 5;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] key_n = '1, key_state, key_press, key_release;
  logic any_press;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  debounce_multi #(.N(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .key_state(key_state),
    .key_press(key_press), .key_release(key_release), .any_press(any_press)
  );
  logic [N-1:0] d1, d2, m_state, m_press, m_rel;
  logic m_any;
  logic [DB-1:0] win [N];
  int since [N];
  int held [N];
  task automatic model_reset();
    d1 = '1; d2 = '1; m_state = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
    for (int c = 0; c < N; c++) begin win[c] = '0; since[c] = DB; held[c] = 0; end
  endtask
  // A level change is accepted once the last DB synchronised samples all
  // disagree with the current level and DB edges have passed since the last event.
  task automatic model_edge();
    m_press = '0; m_rel = '0;
    for (int c = 0; c < N; c++) begin
      logic seen;
      seen = ~d2[c]; d2[c] = d1[c]; d1[c] = key_n[c];
      win[c] = {win[c][DB-2:0], seen};
      if (since[c] < DB) since[c]++;
      if (since[c] >= DB && win[c] == {DB{~m_state[c]}}) begin
        m_state[c] = ~m_state[c];
        since[c] = 0;
        held[c] = 0;
        if (m_state[c]) m_press[c] = 1'b1; else m_rel[c] = 1'b1;
      end else if (m_state[c]) begin
        held[c]++;
`ifdef DEBOUNCE_REPEAT_EN
        if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RP == 0)) m_press[c] = 1'b1;
`endif
      end else held[c] = 0;
    end
    m_any = |m_press;
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0; key_n = '1; model_reset();
    tick(); tick();
    rst = 1'b1;
  endtask
  task automatic test_reset();
    int at;
    rst = 1'b0; key_n = 2'b00; model_reset();
    tick(); tick();
    checks++;
    if ({key_state, key_press, key_release, any_press} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {key_state, key_press, key_release, any_press});
    end
    rst = 1'b1; at = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (key_press == 2'b11 && at < 0) at = k;
      checks++;
      if ({key_state, key_press, key_release, any_press} !== {m_state, m_press, m_rel, m_any}) begin
        errors++; $display("FAIL reset_release cyc %0d got %b want %b", k, {key_state, key_press, key_release, any_press}, {m_state, m_press, m_rel, m_any});
      end
    end
    checks++;
    if (at !== 6) begin errors++; $display("FAIL reset_latency got %0d want 6", at); end
  endtask
  task automatic test_clean();
    int tp, tr;
    do_reset(); tp = -1; tr = -1;
    for (int k = 1; k <= 32; k++) begin
      key_n = (k <= 20) ? 2'b10 : 2'b11;
      tick();
      if (key_press[0] && tp < 0) tp = k;
      if (key_release[0] && tr < 0) tr = k;
      checks++;
      if ({key_state, key_press, key_release, any_press} !== {m_state, m_press, m_rel, m_any}) begin
        errors++; $display("FAIL clean cyc %0d got %b want %b", k, {key_state, key_press, key_release, any_press}, {m_state, m_press, m_rel, m_any});
      end
    end
    checks++;
    if (tp !== 6 || tr !== 26) begin errors++; $display("FAIL clean_latency got press %0d release %0d want 6 26", tp, tr); end
  endtask
  task automatic test_bounce();
    logic [0:17] pat;
    int np, tp;
    pat = 18'b000100010000000000;
    do_reset(); np = 0; tp = -1;
    for (int k = 0; k < 18; k++) begin
      key_n = {1'b1, pat[k]};
      tick();
      if (key_press[0]) begin np++; tp = k; end
      checks++;
      if ({key_state, key_press, key_release, any_press} !== {m_state, m_press, m_rel, m_any}) begin
        errors++; $display("FAIL bounce cyc %0d got %b want %b", k, {key_state, key_press, key_release, any_press}, {m_state, m_press, m_rel, m_any});
      end
    end
    checks++;
    if (np !== 1 || tp !== 13) begin errors++; $display("FAIL bounce_press got count %0d at %0d want 1 at 13", np, tp); end
  endtask
  task automatic test_simultaneous();
    int both, r0, r1;
    do_reset(); both = 0; r0 = -1; r1 = -1;
    for (int k = 1; k <= 26; k++) begin
      key_n = (k <= 12) ? 2'b00 : (k <= 14) ? 2'b10 : 2'b11;
      tick();
      if (key_press == 2'b11 && any_press) both++;
      if (key_release[0]) r0 = k;
      if (key_release[1]) r1 = k;
      checks++;
      if ({key_state, key_press, key_release, any_press} !== {m_state, m_press, m_rel, m_any}) begin
        errors++; $display("FAIL simul cyc %0d got %b want %b", k, {key_state, key_press, key_release, any_press}, {m_state, m_press, m_rel, m_any});
      end
    end
    checks++;
    if (both !== 1 || r0 - r1 !== 2) begin errors++; $display("FAIL simul_order got both %0d gap %0d want 1 2", both, r0 - r1); end
  endtask
  task automatic test_reset_mid();
    int tp;
    do_reset(); key_n = 2'b10;
    tick(); tick(); tick();
    rst = 1'b0; model_reset(); tp = -1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({key_state, key_press, any_press} !== 5'b0) begin
        errors++; $display("FAIL reset_mid_hold got %b want 0", {key_state, key_press, any_press});
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (key_press[0] && tp < 0) tp = k;
      checks++;
      if ({key_state, key_press, key_release, any_press} !== {m_state, m_press, m_rel, m_any}) begin
        errors++; $display("FAIL reset_mid cyc %0d got %b want %b", k, {key_state, key_press, key_release, any_press}, {m_state, m_press, m_rel, m_any});
      end
    end
    checks++;
    if (tp !== 6) begin errors++; $display("FAIL reset_mid_latency got %0d want 6", tp); end
  endtask
  task automatic test_repeat();
    int np, want;
`ifdef DEBOUNCE_REPEAT_EN
    want = 7;
`else
    want = 1;
`endif
    do_reset(); np = 0;
    for (int k = 1; k <= 60; k++) begin
      key_n = (k <= 40) ? 2'b10 : 2'b11;
      tick();
      if (key_press[0]) np++;
      checks++;
      if ({key_state, key_press, key_release, any_press} !== {m_state, m_press, m_rel, m_any}) begin
        errors++; $display("FAIL repeat cyc %0d got %b want %b", k, {key_state, key_press, key_release, any_press}, {m_state, m_press, m_rel, m_any});
      end
    end
    checks++;
    if (np !== want) begin errors++; $display("FAIL repeat_count got %0d want %0d", np, want); end
  endtask
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(6) == 0) key_n[c] = ~key_n[c];
      tick();
      checks++;
      if ({key_state, key_press, key_release, any_press} !== {m_state, m_press, m_rel, m_any}) begin
        errors++; $display("FAIL random cyc %0d got %b want %b", k, {key_state, key_press, key_release, any_press}, {m_state, m_press, m_rel, m_any});
      end
    end
  endtask
  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Multi-channel push-button conditioner for board-level debug inputs, parametrised in channel count and debounce time.
- Each active-low key is synchronised, debounced with its own stability counter, and turned into a level plus one-cycle press and release pulses.
- Placed between the raw board buttons and the debug and control logic (single-step, mode select, display page).
- Unlike the single-edge debouncer, every channel times out independently and release events are reported.

Parameters:
- N, 4, number of key channels (>=1).
- DB_CYCLES, 262144, consecutive stable cycles required before a level change is accepted (>=2).
- REPEAT_DELAY, 50000000, cycles from the accepted press to the first auto-repeat pulse (>=1; used only with the optional feature).
- REPEAT_PERIOD, 10000000, cycles between later auto-repeat pulses (>=1; used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset.
- key_n  input  N  raw buttons, asynchronous, active-low (0 = pressed).
- key_state  output  N  debounced level, 1 = pressed.
- key_press  output  N  one-cycle pulse per accepted press (and per repeat when enabled).
- key_release  output  N  one-cycle pulse per accepted release.
- any_press  output  1  OR-reduction of key_press, registered in the same cycle as key_press.

Behaviour:
- Reset (rst=0, asynchronous):
  - synchroniser flops = 1 (released);
  - all counters = 0;
  - key_state, key_press, key_release and any_press = 0.
  - Reset at any time, including mid-count, discards partial counts.
  - After rst deasserts, a held key needs the full latency again.
- Per-channel synchroniser: two flops, s1 <= key_n[i] and s2 <= s1. Nothing else samples key_n directly.
- Mismatch: m = (~s2) != key_state[i].
- Stability counter:
  - Width is the minimum holding DB_CYCLES-1, computed internally.
  - On an edge with m=1 and cnt == DB_CYCLES-1: key_state[i] toggles and cnt <= 0. Pulse key_press[i] if the new state is 1, otherwise key_release[i].
  - On an edge with m=1 otherwise: cnt <= cnt+1.
  - On an edge with m=0: cnt <= 0. A single bounce restarts the count.
- Latency: the input first sampled low at edge E0 gives key_state/key_press high after edge E(DB_CYCLES+1), i.e. DB_CYCLES+2 clocks. Release has the same latency.
- Pulses are registered, exactly one cycle wide, and zero on all other cycles.
  - key_press[i] and key_release[i] are never high together.
  - A new event can occur at the earliest DB_CYCLES cycles after the previous one.
- Channels are fully independent. Simultaneous events on several channels pulse in the same cycle, and any_press is then 1 for that single cycle.
- No wrap-around: cnt never exceeds DB_CYCLES-1.

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- When defined:
  - Each channel has a repeat counter, cleared by the accepted-press event and by key_state[i]=0.
  - While key_state[i]=1, extra key_press[i] pulses occur REPEAT_DELAY cycles after the original press pulse, then every REPEAT_PERIOD cycles.
  - A release stops repeats at once.
  - A repeat pulse never coincides with key_release.
- When undefined:
  - No repeat counters are synthesised.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - key_press pulses exactly once per accepted press.

Test Plan:
- Common settings: N=2, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Reset: rst=0 with key_n=2'b00 -> all outputs 0. Release rst with keys held -> key_press=2'b11 exactly 6 clocks after the first rising edge with rst=1.
- Clean press/release ch0: key_n[0] 1->0 held 20 cycles, then 0->1 -> key_press[0] high for 1 cycle at +6 clocks and key_state[0]=1. Then key_release[0] high for 1 cycle at +6 clocks after the release and key_state[0]=0. Channel 1 stays 0 throughout.
- Bounce: key_n[0] low 3, high 1, low 3, high 1, then low steady -> no pulse during the bounces. A single key_press[0] arrives 6 clocks after the final falling edge.
- Simultaneous: both keys fall on the same edge -> key_press=2'b11 and any_press=1 in the same single cycle. Ch1 released 2 cycles before ch0 -> key_release[1] precedes key_release[0] by 2 cycles.
- Reset mid-count: ch0 low for 3 cycles, then pulse rst low, keeping the key low -> no key_press during reset. key_press[0] at 6 clocks after rst release.
- Auto-repeat (build with DEBOUNCE_REPEAT_EN): hold ch0 for 40 cycles -> press pulses at t, t+10, t+15, t+20, ... and none after release. Same stimulus without the macro -> only the pulse at t.
